// File: rtl/mvu_job_responder_pkg.sv
// Shared types and constants for the MVU job responder.
// Holds the per-hart job snapshot record, the responder FSM state encoding
// and the field positions inside csr_mvucommand.
package mvu_job_responder_pkg;

    localparam int MVU_CMD_MODE_MSB = 31;
    localparam int MVU_CMD_MODE_LSB = 30;
    localparam int MVU_CNT_W_DEF    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } mvu_resp_state_e;

    // countdown is kept zero-extended to 32 bits; the module truncates it
    // to its own CNT_W when loading the counter.
    typedef struct packed {
        logic [1:0]  mul_mode;
        logic [31:0] countdown;
        logic [31:0] wbaseptr;
        logic [31:0] ibaseptr;
        logic [31:0] obaseptr;
    } mvu_job_t;

    function automatic logic [1:0] cmd_mode(input logic [31:0] cmd);
        return cmd[MVU_CMD_MODE_MSB:MVU_CMD_MODE_LSB];
    endfunction

endpackage

// File: rtl/mvu_job_responder_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after
// the pointer, returning both a one-hot grant and the grant index.
module mvu_rr_arbiter
    import mvu_job_responder_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    int j_s;

    // Rotating priority search starting at the pointer.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        j_s     = 0;
        for (int k = 0; k < N; k++) begin
            j_s = (int'(ptr_i) + k) % N;
            if (!valid_o && req_i[j_s]) begin
                valid_o    = 1'b1;
                gnt_o[j_s] = 1'b1;
                idx_o      = IDX_W'(j_s);
            end else begin
                valid_o = valid_o;
            end
        end
    end

endmodule

// File: rtl/mvu_job_responder.sv
// MVU-side job responder: snapshots per-hart CSR job fields on mvu_start,
// round-robins pending jobs onto the single engine port, counts each job down
// against engine stalls and returns a one-cycle mvu_irq to the issuing hart.
// Optional feature macro: MVU_STATUS_EN adds the per-hart csr_mvustatus_o.
`ifndef PITO_NUM_HARTS
`define PITO_NUM_HARTS 8
`endif
module mvu_job_responder
    import mvu_job_responder_pkg::*;
#(
    parameter int  NUM_HARTS = `PITO_NUM_HARTS,
    parameter int  CNT_W     = MVU_CNT_W_DEF,
    localparam int HID_W     = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_HARTS-1:0]    mvu_start,
    input  logic [32*NUM_HARTS-1:0] csr_mvucommand,
    input  logic [32*NUM_HARTS-1:0] csr_mvuwbaseptr,
    input  logic [32*NUM_HARTS-1:0] csr_mvuibaseptr,
    input  logic [32*NUM_HARTS-1:0] csr_mvuobaseptr,
    output logic [NUM_HARTS-1:0]    mvu_irq_o,
    output logic [NUM_HARTS-1:0]    overrun_o,
    input  logic                    eng_stall,
    output logic                    eng_start,
    output logic [HID_W-1:0]        eng_hart_id,
    output logic [1:0]              eng_mul_mode,
    output logic [31:0]             eng_wbaseptr,
    output logic [31:0]             eng_ibaseptr,
    output logic [31:0]             eng_obaseptr,
    output logic                    eng_step
`ifdef MVU_STATUS_EN
    ,
    output logic [32*NUM_HARTS-1:0] csr_mvustatus_o
`endif
);

    mvu_resp_state_e       state_q;
    logic [NUM_HARTS-1:0]  pending_q, overrun_q, irq_q;
    logic [NUM_HARTS-1:0]  running_s, accept_s, clr_s, gnt_s;
    logic [HID_W-1:0]      cur_q, ptr_q, gidx_s;
    logic                  gvalid_s;
    logic [CNT_W-1:0]      count_q;
    mvu_job_t              snap_q [NUM_HARTS];
    logic                  eng_start_q;
    logic [1:0]            mode_q;
    logic [31:0]           wptr_q, iptr_q, optr_q;

    mvu_rr_arbiter #(.N(NUM_HARTS), .IDX_W(HID_W)) u_arb (
        .req_i   (pending_q),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt_s),
        .idx_o   (gidx_s),
        .valid_o (gvalid_s)
    );

    // Busy/accept decode; running covers GRANT and RUN only, so a restart in DONE is accepted.
    always_comb begin
        running_s = '0;
        if (state_q == GRANT || state_q == RUN) begin
            running_s[cur_q] = 1'b1;
        end else begin
            running_s = '0;
        end
        accept_s = mvu_start & ~(pending_q | running_s);
        if (state_q == IDLE && gvalid_s) begin
            clr_s = gnt_s;
        end else begin
            clr_s = '0;
        end
    end

    // Pending set by accepted starts, cleared by the grant; overrun is sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            pending_q <= (pending_q & ~clr_s) | accept_s;
            overrun_q <= overrun_q | (mvu_start & ~accept_s);
        end
    end

    // Per-hart job snapshot taken only on an accepted start.
    always_ff @(posedge clk) begin
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (rst) begin
                snap_q[h] <= '0;
            end else if (accept_s[h]) begin
                snap_q[h].mul_mode  <= cmd_mode(csr_mvucommand[h*32 +: 32]);
                snap_q[h].countdown <= 32'(csr_mvucommand[h*32 +: CNT_W]);
                snap_q[h].wbaseptr  <= csr_mvuwbaseptr[h*32 +: 32];
                snap_q[h].ibaseptr  <= csr_mvuibaseptr[h*32 +: 32];
                snap_q[h].obaseptr  <= csr_mvuobaseptr[h*32 +: 32];
            end else begin
                snap_q[h] <= snap_q[h];
            end
        end
    end

    // Responder FSM with registered engine launch, held job fields and irq pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            ptr_q       <= '0;
            count_q     <= '0;
            eng_start_q <= 1'b0;
            mode_q      <= 2'b00;
            wptr_q      <= 32'h0;
            iptr_q      <= 32'h0;
            optr_q      <= 32'h0;
            irq_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    irq_q <= '0;
                    if (gvalid_s) begin
                        state_q     <= GRANT;
                        cur_q       <= gidx_s;
                        eng_start_q <= 1'b1;
                        mode_q      <= snap_q[gidx_s].mul_mode;
                        wptr_q      <= snap_q[gidx_s].wbaseptr;
                        iptr_q      <= snap_q[gidx_s].ibaseptr;
                        optr_q      <= snap_q[gidx_s].obaseptr;
                    end else begin
                        eng_start_q <= 1'b0;
                    end
                end
                GRANT: begin
                    eng_start_q <= 1'b0;
                    count_q     <= snap_q[cur_q].countdown[CNT_W-1:0];
                    if (snap_q[cur_q].countdown[CNT_W-1:0] == {CNT_W{1'b0}}) begin
                        state_q       <= DONE;
                        irq_q[cur_q]  <= 1'b1;
                    end else begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (!eng_stall) begin
                        count_q <= count_q - CNT_W'(1);
                        if (count_q == CNT_W'(1)) begin
                            state_q      <= DONE;
                            irq_q[cur_q] <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end else begin
                        count_q <= count_q;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    irq_q   <= '0;
                    ptr_q   <= (cur_q == HID_W'(NUM_HARTS - 1)) ? {HID_W{1'b0}} : cur_q + HID_W'(1);
                    mode_q  <= 2'b00;
                    wptr_q  <= 32'h0;
                    iptr_q  <= 32'h0;
                    optr_q  <= 32'h0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mvu_irq_o    = irq_q;
    assign overrun_o    = overrun_q;
    assign eng_start    = eng_start_q;
    assign eng_hart_id  = (state_q == IDLE) ? {HID_W{1'b0}} : cur_q;
    assign eng_mul_mode = mode_q;
    assign eng_wbaseptr = wptr_q;
    assign eng_ibaseptr = iptr_q;
    assign eng_obaseptr = optr_q;
    assign eng_step     = (state_q == RUN) && !eng_stall;

`ifdef MVU_STATUS_EN
    logic [NUM_HARTS-1:0]    done_sticky_q;
    logic [32*NUM_HARTS-1:0] status_q;

    // Status word per hart: pending, running, done_sticky and remaining count.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_sticky_q <= '0;
            status_q      <= '0;
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (accept_s[h]) begin
                    done_sticky_q[h] <= 1'b0;
                end else if (state_q == DONE && cur_q == HID_W'(h)) begin
                    done_sticky_q[h] <= 1'b1;
                end else begin
                    done_sticky_q[h] <= done_sticky_q[h];
                end
                status_q[h*32 +: 32] <= {((running_s[h] && state_q == RUN) ? 16'(count_q) : 16'h0000),
                                         13'h0000, done_sticky_q[h], running_s[h], pending_q[h]};
            end
        end
    end

    assign csr_mvustatus_o = status_q;
`endif

endmodule
